// File: rtl/dot_if.sv
// Handshake bundle between an operand source, the dot-product unit
// and its result consumer.
interface dot_if #(
    parameter int ARGW = 16,
    parameter int RESW = 24
);
    logic [2*ARGW-1:0] arg_data;
    logic              arg_valid;
    logic              arg_ready;
    logic [RESW-1:0]   res_data;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output arg_data,
        output arg_valid,
        input  arg_ready,
        input  res_data,
        input  res_valid,
        output res_ready
    );

    modport slave (
        input  arg_data,
        input  arg_valid,
        output arg_ready,
        output res_data,
        output res_valid,
        input  res_ready
    );
endinterface

// File: rtl/dot.sv
// Fixed-point dot product: accumulates LEN scaled products a*b,
// then presents the sum until the consumer takes it.
module dot #(
    parameter int ARGW = 16,
    parameter int RESW = 24,
    parameter int FRAC = 8,
    parameter int LEN  = 4
) (
    input logic  clk,
    input logic  rst,
    dot_if.slave bus
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {
        ACCUM,
        OUTPUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic                   run;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nx;
    logic signed [RESW-1:0] acc;
    logic signed [RESW-1:0] acc_nx;

    logic signed [ARGW-1:0]   a;
    logic signed [ARGW-1:0]   b;
    logic signed [2*ARGW-1:0] prod;
    logic signed [2*ARGW-1:0] shf;
    logic signed [RESW-1:0]   term;

    logic take;
    logic give;

    assign a    = bus.arg_data[2*ARGW-1:ARGW];
    assign b    = bus.arg_data[ARGW-1:0];
    assign prod = a * b;
    assign shf  = prod >>> FRAC;
    // Signed size cast: truncates when narrower, sign-extends when wider.
    assign term = RESW'(shf);

    assign bus.arg_ready = run && (state == ACCUM);
    assign bus.res_valid = (state == OUTPUT);
    assign bus.res_data  = acc;

    assign take = bus.arg_valid && bus.arg_ready;
    assign give = bus.res_valid && bus.res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
            run   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
            cnt   <= cnt_nx;
            acc   <= acc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        unique case (state)
            ACCUM: begin
                if (take) begin
                    acc_nx = (cnt == '0) ? term : acc + term;
                    if (cnt == LAST) begin
                        cnt_nx   = '0;
                        state_nx = OUTPUT;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            OUTPUT: begin
                if (give) begin
                    state_nx = ACCUM;
                end
            end
            default: begin
                state_nx = ACCUM;
            end
        endcase
    end
endmodule

// File: tb/tb_dot.sv
// Randomised and directed bench for dot, LEN=4 and LEN=1 instances,
// checked against an arithmetic dot-product model.
module tb_dot;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dot_if #(.ARGW(16), .RESW(24)) b4 ();
    dot_if #(.ARGW(16), .RESW(24)) b1 ();

    dot #(.ARGW(16), .RESW(24), .FRAC(8), .LEN(4)) u4 (
        .clk(clk),
        .rst(rst),
        .bus(b4.slave)
    );

    dot #(.ARGW(16), .RESW(24), .FRAC(8), .LEN(1)) u1 (
        .clk(clk),
        .rst(rst),
        .bus(b1.slave)
    );

    int          cmp_n = 0;
    int          err_n = 0;
    longint      cyc = 0;
    logic [23:0] got4[$];
    logic [23:0] got1[$];
    longint      at4[$];
    longint      at1[$];

    always @(posedge clk) begin
        if (rst && b4.res_valid && b4.res_ready) begin
            got4.push_back(b4.res_data);
            at4.push_back(cyc);
        end
        if (rst && b1.res_valid && b1.res_ready) begin
            got1.push_back(b1.res_data);
            at1.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    function automatic longint term(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p >>> 8;
    endfunction

    task automatic put(input bit one, input logic [15:0] a, input logic [15:0] b);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        if (one) begin
            b1.arg_valid = 1'b1;
            b1.arg_data = {a, b};
        end else begin
            b4.arg_valid = 1'b1;
            b4.arg_data = {a, b};
        end
        while (!ok && n < 40) begin
            ok = one ? b1.arg_ready : b4.arg_ready;
            @(negedge clk);
            n++;
        end
        cmp_n++;
        if (!ok) begin
            err_n++;
            $display("FAIL put_timeout inst=%0d pair not accepted in %0d cycles", one, n);
        end
    endtask

    task automatic idle();
        b4.arg_valid = 1'b0;
        b1.arg_valid = 1'b0;
    endtask

    task automatic wait_res(input bit one, input int n, input int budget);
        int k;
        k = 0;
        while (((one ? got1.size() : got4.size()) < n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        cmp_n++;
        if (b4.arg_ready !== 1'b0 || b4.res_valid !== 1'b0 || b4.res_data !== 24'h0) begin
            err_n++;
            $display("FAIL reset_outputs got rdy=%b vld=%b data=%h want 0 0 000000",
                     b4.arg_ready, b4.res_valid, b4.res_data);
        end
        cmp_n++;
        if (b1.arg_ready !== 1'b0 || b1.res_valid !== 1'b0 || b1.res_data !== 24'h0) begin
            err_n++;
            $display("FAIL reset_outputs_len1 got rdy=%b vld=%b data=%h want 0 0 000000",
                     b1.arg_ready, b1.res_valid, b1.res_data);
        end
        rst = 1'b1;
        #1;
        cmp_n++;
        if (b4.arg_ready !== 1'b0) begin
            err_n++;
            $display("FAIL release_no_edge got arg_ready=%b want 0", b4.arg_ready);
        end
        @(negedge clk);
        cmp_n++;
        if (b4.arg_ready !== 1'b1 || b4.res_valid !== 1'b0) begin
            err_n++;
            $display("FAIL release_first_edge got rdy=%b vld=%b want 1 0",
                     b4.arg_ready, b4.res_valid);
        end
    endtask

    task automatic test_basic();
        got4.delete();
        b4.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) put(0, 16'h0100, 16'h0100);
        idle();
        wait_res(0, 1, 20);
        cmp_n++;
        if (got4.size() != 1) begin
            err_n++;
            $display("FAIL basic_count got %0d want 1", got4.size());
        end else if (got4[0] !== 24'h000400) begin
            err_n++;
            $display("FAIL basic_value got %h want 000400", got4[0]);
        end
    endtask

    task automatic test_signed();
        logic [15:0] av[4] = '{16'hff00, 16'h0100, 16'h0000, 16'h0000};
        logic [15:0] bv[4] = '{16'h0300, 16'h0100, 16'h1234, 16'h0000};
        got4.delete();
        b4.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) put(0, av[i], bv[i]);
        idle();
        wait_res(0, 1, 20);
        cmp_n++;
        if (got4.size() != 1) begin
            err_n++;
            $display("FAIL signed_count got %0d want 1", got4.size());
        end else if (got4[0] !== 24'hfffe00) begin
            err_n++;
            $display("FAIL signed_value got %h want fffe00", got4[0]);
        end
    endtask

    task automatic test_wrap();
        got4.delete();
        b4.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) put(0, 16'h7fff, 16'h7fff);
        idle();
        wait_res(0, 1, 20);
        cmp_n++;
        if (got4.size() != 1) begin
            err_n++;
            $display("FAIL wrap_count got %0d want 1", got4.size());
        end else if (got4[0] !== 24'hfffc00) begin
            err_n++;
            $display("FAIL wrap_value got %h want fffc00", got4[0]);
        end
    endtask

    task automatic test_backpressure();
        longint s;
        logic [23:0] want;
        logic [15:0] a;
        logic [15:0] b;
        int bad;
        s = 0;
        bad = 0;
        got4.delete();
        b4.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s += term(a, b);
            put(0, a, b);
        end
        want = 24'(s);
        b4.arg_data = 32'h1111_2222;
        for (int i = 0; i < 10; i++) begin
            if (b4.res_valid !== 1'b1 || b4.arg_ready !== 1'b0 || b4.res_data !== want) begin
                bad++;
                if (bad == 1) begin
                    $display("FAIL bp_hold cycle=%0d got vld=%b rdy=%b data=%h want 1 0 %h",
                             i, b4.res_valid, b4.arg_ready, b4.res_data, want);
                end
            end
            @(negedge clk);
        end
        cmp_n++;
        if (bad != 0) err_n++;
        b4.res_ready = 1'b1;
        @(negedge clk);
        idle();
        b4.res_ready = 1'b0;
        cmp_n++;
        if (b4.arg_ready !== 1'b1 || b4.res_valid !== 1'b0) begin
            err_n++;
            $display("FAIL bp_return got rdy=%b vld=%b want 1 0", b4.arg_ready, b4.res_valid);
        end
        cmp_n++;
        if (got4.size() != 1) begin
            err_n++;
            $display("FAIL bp_count got %0d want 1", got4.size());
        end else if (got4[0] !== want) begin
            err_n++;
            $display("FAIL bp_value got %h want %h", got4[0], want);
        end
        b4.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) put(0, 16'h0100, 16'h0100);
        idle();
        wait_res(0, 2, 20);
        cmp_n++;
        if (got4.size() != 2) begin
            err_n++;
            $display("FAIL bp_fresh_count got %0d want 2", got4.size());
        end else if (got4[1] !== 24'h000400) begin
            err_n++;
            $display("FAIL bp_fresh_value got %h want 000400", got4[1]);
        end
    endtask

    task automatic test_reset_mid();
        got4.delete();
        b4.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(0, 16'h0300, 16'h0200);
        idle();
        cmp_n++;
        if (b4.res_valid !== 1'b1) begin
            err_n++;
            $display("FAIL pend_valid got %b want 1", b4.res_valid);
        end
        rst = 1'b0;
        b4.res_ready = 1'b1;
        @(negedge clk);
        cmp_n++;
        if (b4.arg_ready !== 1'b0 || b4.res_valid !== 1'b0 || b4.res_data !== 24'h0) begin
            err_n++;
            $display("FAIL mid_reset_outputs got rdy=%b vld=%b data=%h want 0 0 000000",
                     b4.arg_ready, b4.res_valid, b4.res_data);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_n++;
        if (got4.size() != 0 || b4.res_valid !== 1'b0) begin
            err_n++;
            $display("FAIL pend_dropped got transfers=%0d vld=%b want 0 0",
                     got4.size(), b4.res_valid);
        end
        for (int i = 0; i < 2; i++) put(0, 16'h7000, 16'h7000);
        idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) put(0, 16'h0100, 16'h0100);
        idle();
        wait_res(0, 1, 20);
        cmp_n++;
        if (got4.size() != 1) begin
            err_n++;
            $display("FAIL mid_count got %0d want 1", got4.size());
        end else if (got4[0] !== 24'h000400) begin
            err_n++;
            $display("FAIL mid_value got %h want 000400", got4[0]);
        end
    endtask

    task automatic test_streaming();
        got4.delete();
        at4.delete();
        b4.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) put(0, 16'h0100, 16'h0200);
        idle();
        wait_res(0, 2, 30);
        cmp_n++;
        if (got4.size() != 2) begin
            err_n++;
            $display("FAIL stream_count got %0d want 2", got4.size());
        end else begin
            if (got4[0] !== 24'h000800 || got4[1] !== 24'h000800) begin
                err_n++;
                $display("FAIL stream_value got %h %h want 000800 000800", got4[0], got4[1]);
            end
            cmp_n++;
            if (at4[1] - at4[0] != 5) begin
                err_n++;
                $display("FAIL stream_spacing got %0d want 5", at4[1] - at4[0]);
            end
        end
    endtask

    task automatic test_len1();
        logic [23:0] exp[$];
        logic [15:0] a;
        logic [15:0] b;
        got1.delete();
        at1.delete();
        b1.res_ready = 1'b1;
        put(1, 16'h0200, 16'h0200);
        exp.push_back(24'h000400);
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            exp.push_back(24'(term(a, b)));
            put(1, a, b);
        end
        idle();
        wait_res(1, 6, 30);
        cmp_n++;
        if (got1.size() != 6) begin
            err_n++;
            $display("FAIL len1_count got %0d want 6", got1.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                cmp_n++;
                if (got1[i] !== exp[i]) begin
                    err_n++;
                    $display("FAIL len1_value idx=%0d got %h want %h", i, got1[i], exp[i]);
                end
            end
            cmp_n++;
            if (at1[5] - at1[1] != 8) begin
                err_n++;
                $display("FAIL len1_spacing got %0d want 8", at1[5] - at1[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] exp[$];
        got4.delete();
        fork
            begin
                logic [15:0] a;
                logic [15:0] b;
                longint s;
                for (int p = 0; p < 6; p++) begin
                    s = 0;
                    for (int i = 0; i < 4; i++) begin
                        if ($urandom_range(0, 2) == 0) begin
                            b4.arg_valid = 1'b0;
                            repeat ($urandom_range(1, 3)) @(negedge clk);
                        end
                        a = 16'($urandom);
                        b = 16'($urandom);
                        s += term(a, b);
                        put(0, a, b);
                    end
                    exp.push_back(24'(s));
                end
                idle();
            end
            begin
                int n;
                n = 0;
                while (got4.size() < 6 && n < 600) begin
                    b4.res_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n++;
                end
                b4.res_ready = 1'b1;
            end
        join
        wait_res(0, 6, 20);
        cmp_n++;
        if (got4.size() != 6) begin
            err_n++;
            $display("FAIL rand_count got %0d want 6", got4.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                cmp_n++;
                if (got4[i] !== exp[i]) begin
                    err_n++;
                    $display("FAIL rand_value idx=%0d got %h want %h", i, got4[i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        b4.arg_valid = 1'b0;
        b4.arg_data = '0;
        b4.res_ready = 1'b0;
        b1.arg_valid = 1'b0;
        b1.arg_data = '0;
        b1.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_streaming();
        test_len1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
